// File: rtl/inst_encoder_loader.sv
// Boot/self-test program loader: packs symbolic commands into RV32I words and
// writes them to consecutive instruction-memory addresses, one word per two cycles.
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_ovf,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_XOR   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_AND   = 6'd4;
  localparam logic [5:0] OP_SLL   = 6'd5;
  localparam logic [5:0] OP_SRL   = 6'd6;
  localparam logic [5:0] OP_SRA   = 6'd7;
  localparam logic [5:0] OP_SLT   = 6'd8;
  localparam logic [5:0] OP_SLTU  = 6'd9;
  localparam logic [5:0] OP_LB    = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd11;
  localparam logic [5:0] OP_ADDI  = 6'd12;
  localparam logic [5:0] OP_SLLI  = 6'd13;
  localparam logic [5:0] OP_SLTI  = 6'd14;
  localparam logic [5:0] OP_SLTIU = 6'd15;
  localparam logic [5:0] OP_XORI  = 6'd16;
  localparam logic [5:0] OP_SRLI  = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_ORI   = 6'd19;
  localparam logic [5:0] OP_ANDI  = 6'd20;
  localparam logic [5:0] OP_SB    = 6'd21;
  localparam logic [5:0] OP_SW    = 6'd22;
  localparam logic [5:0] OP_LUI   = 6'd23;
  localparam logic [5:0] OP_AUIPC = 6'd24;
  localparam logic [5:0] OP_BEQ   = 6'd25;
  localparam logic [5:0] OP_BNE   = 6'd26;
  localparam logic [5:0] OP_BLT   = 6'd27;
  localparam logic [5:0] OP_BGE   = 6'd28;
  localparam logic [5:0] OP_BLTU  = 6'd29;
  localparam logic [5:0] OP_BGEU  = 6'd30;
  localparam logic [5:0] OP_JALR  = 6'd31;
  localparam logic [5:0] OP_JAL   = 6'd32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_FINISH} state_t;

  function automatic logic [31:0] f_enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] f_enc_i(input logic [11:0] imm12, input logic [2:0] f3,
                                          input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs1);
    return {imm12, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] f_enc_sh(input logic [6:0] f7, input logic [4:0] shamt,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [4:0] rs1);
    return {f7, shamt, rs1, f3, rd, OPC_OPIMM};
  endfunction

  function automatic logic [31:0] f_enc_s(input logic [11:0] imm12, input logic [2:0] f3,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OPC_STORE};
  endfunction

  // Branch offsets are even, so imm[0] never reaches the word.
  function automatic logic [31:0] f_enc_b(input logic [12:0] imm13, input logic [2:0] f3,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm13[12], imm13[10:5], rs2, rs1, f3, imm13[4:1], imm13[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] f_enc_j(input logic [20:0] imm21, input logic [4:0] rd);
    return {imm21[20], imm21[10:1], imm21[11], imm21[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic f_legal(input logic [5:0] op);
    return (op <= OP_JAL);
  endfunction

  function automatic logic [31:0] f_encode(input logic [5:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_ADD:   w = f_enc_r(F7_BASE, 3'd0, rd, rs1, rs2);
      OP_SUB:   w = f_enc_r(F7_ALT,  3'd0, rd, rs1, rs2);
      OP_XOR:   w = f_enc_r(F7_BASE, 3'd4, rd, rs1, rs2);
      OP_OR:    w = f_enc_r(F7_BASE, 3'd6, rd, rs1, rs2);
      OP_AND:   w = f_enc_r(F7_BASE, 3'd7, rd, rs1, rs2);
      OP_SLL:   w = f_enc_r(F7_BASE, 3'd1, rd, rs1, rs2);
      OP_SRL:   w = f_enc_r(F7_BASE, 3'd5, rd, rs1, rs2);
      OP_SRA:   w = f_enc_r(F7_ALT,  3'd5, rd, rs1, rs2);
      OP_SLT:   w = f_enc_r(F7_BASE, 3'd2, rd, rs1, rs2);
      OP_SLTU:  w = f_enc_r(F7_BASE, 3'd3, rd, rs1, rs2);
      OP_LB:    w = f_enc_i(imm[11:0], 3'd0, OPC_LOAD,  rd, rs1);
      OP_LW:    w = f_enc_i(imm[11:0], 3'd2, OPC_LOAD,  rd, rs1);
      OP_ADDI:  w = f_enc_i(imm[11:0], 3'd0, OPC_OPIMM, rd, rs1);
      OP_SLLI:  w = f_enc_sh(F7_BASE, imm[4:0], 3'd1, rd, rs1);
      OP_SLTI:  w = f_enc_i(imm[11:0], 3'd2, OPC_OPIMM, rd, rs1);
      OP_SLTIU: w = f_enc_i(imm[11:0], 3'd3, OPC_OPIMM, rd, rs1);
      OP_XORI:  w = f_enc_i(imm[11:0], 3'd4, OPC_OPIMM, rd, rs1);
      OP_SRLI:  w = f_enc_sh(F7_BASE, imm[4:0], 3'd5, rd, rs1);
      OP_SRAI:  w = f_enc_sh(F7_ALT,  imm[4:0], 3'd5, rd, rs1);
      OP_ORI:   w = f_enc_i(imm[11:0], 3'd6, OPC_OPIMM, rd, rs1);
      OP_ANDI:  w = f_enc_i(imm[11:0], 3'd7, OPC_OPIMM, rd, rs1);
      OP_SB:    w = f_enc_s(imm[11:0], 3'd0, rs1, rs2);
      OP_SW:    w = f_enc_s(imm[11:0], 3'd2, rs1, rs2);
      OP_LUI:   w = {imm[31:12], rd, OPC_LUI};
      OP_AUIPC: w = {imm[31:12], rd, OPC_AUIPC};
      OP_BEQ:   w = f_enc_b(imm[12:0], 3'd0, rs1, rs2);
      OP_BNE:   w = f_enc_b(imm[12:0], 3'd1, rs1, rs2);
      OP_BLT:   w = f_enc_b(imm[12:0], 3'd4, rs1, rs2);
      OP_BGE:   w = f_enc_b(imm[12:0], 3'd5, rs1, rs2);
      OP_BLTU:  w = f_enc_b(imm[12:0], 3'd6, rs1, rs2);
      OP_BGEU:  w = f_enc_b(imm[12:0], 3'd7, rs1, rs2);
      OP_JALR:  w = f_enc_i(imm[11:0], 3'd0, OPC_JALR, rd, rs1);
      OP_JAL:   w = f_enc_j(imm[20:0], rd);
      default:  w = '0;
    endcase
    return w;
  endfunction

  state_t          r_state;
  logic            r_last;
  logic [31:0]     w_enc;
  logic            w_legal;
  logic [ADDR_W:0] w_cnt_next;
  logic            w_cnt_full;

  assign w_enc      = f_encode(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
  assign w_legal    = f_legal(cmd_op);
  assign w_cnt_next = word_count + 1'b1;
  assign w_cnt_full = (w_cnt_next == MAX_CNT);

  // imem_addr doubles as the session write pointer; it advances after each write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b0;
      cmd_ready   <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      word_count  <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state     <= S_ACCEPT;
            cmd_ready   <= 1'b1;
            busy        <= 1'b1;
            imem_addr   <= start_addr;
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_ovf     <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (cmd_valid) begin
            if (w_legal) begin
              imem_wdata <= w_enc;
              r_last     <= cmd_last;
              imem_we    <= 1'b1;
              cmd_ready  <= 1'b0;
              r_state    <= S_WRITE;
            end else begin
              err_illegal <= 1'b1;
              if (cmd_last) begin
                cmd_ready <= 1'b0;
                done      <= 1'b1;
                r_state   <= S_FINISH;
              end
            end
          end
        end
        S_WRITE: begin
          imem_addr  <= imem_addr + 1'b1;
          word_count <= w_cnt_next;
          if (r_last || w_cnt_full) begin
            if (w_cnt_full && !r_last) err_ovf <= 1'b1;
            done    <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            cmd_ready <= 1'b1;
            r_state   <= S_ACCEPT;
          end
        end
        S_FINISH: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: table of hand-encoded RV32I words plus
// hand-written sessions for addressing, illegal ops, overflow/wrap and mid-write reset.
module tb_inst_encoder_loader;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [7:0]  start_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;
  logic        cmd_last;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err_illegal, err_ovf;
  logic [8:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;

  inst_encoder_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .start_addr(start_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_illegal(err_illegal),
    .err_ovf(err_ovf), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [7:0] a);
    load_start = 1'b1;
    start_addr = a;
    tick();
    load_start = 1'b0;
  endtask

  // Returns 1 ns after the handshake edge.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_last = last;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 16) begin
      tick();
      n++;
    end
    chk("hs_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic expect_write(input string nm, input logic [7:0] a, input logic [31:0] d);
    chk({nm, "_we"},   {31'd0, imem_we}, 32'd1);
    chk({nm, "_addr"}, {24'd0, imem_addr}, {24'd0, a});
    chk({nm, "_data"}, imem_wdata, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'd12, 5'd5,  5'd0,  5'd31, 32'hFFFF_FFFF, 32'hFFF00293};
    tbl[1]  = '{6'd22, 5'd7,  5'd1,  5'd2,  32'h0000_0008, 32'h0020A423};
    tbl[2]  = '{6'd23, 5'd3,  5'd7,  5'd9,  32'h1234_5000, 32'h123451B7};
    tbl[3]  = '{6'd1,  5'd4,  5'd5,  5'd6,  32'hFFFF_FFFF, 32'h40628233};
    tbl[4]  = '{6'd7,  5'd7,  5'd8,  5'd9,  32'h0000_0000, 32'h409453B3};
    tbl[5]  = '{6'd9,  5'd1,  5'd2,  5'd3,  32'h0000_0000, 32'h003130B3};
    tbl[6]  = '{6'd11, 5'd10, 5'd11, 5'd0,  32'hFFFF_FFFC, 32'hFFC5A503};
    tbl[7]  = '{6'd13, 5'd1,  5'd1,  5'd0,  32'hFFFF_FFE3, 32'h00309093};
    tbl[8]  = '{6'd18, 5'd2,  5'd3,  5'd0,  32'h0000_001F, 32'h41F1D113};
    tbl[9]  = '{6'd21, 5'd0,  5'd2,  5'd3,  32'hFFFF_FFFF, 32'hFE310FA3};
    tbl[10] = '{6'd24, 5'd31, 5'd0,  5'd0,  32'hABCD_E123, 32'hABCDEF97};
    tbl[11] = '{6'd26, 5'd0,  5'd5,  5'd6,  32'hFFFF_FFF8, 32'hFE629CE3};
    tbl[12] = '{6'd30, 5'd0,  5'd1,  5'd2,  32'h0000_0800, 32'h0020F0E3};
    tbl[13] = '{6'd31, 5'd1,  5'd6,  5'd0,  32'h0000_07FF, 32'h7FF300E7};
    tbl[14] = '{6'd32, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 32'hFFDFF06F};
    tbl[15] = '{6'd15, 5'd3,  5'd4,  5'd0,  32'h0000_0005, 32'h00523193};
    tbl[16] = '{6'd4,  5'd1,  5'd2,  5'd3,  32'h0000_0000, 32'h003170B3};
    tbl[17] = '{6'd10, 5'd2,  5'd3,  5'd0,  32'h0000_0001, 32'h00118103};
    tbl[18] = '{6'd27, 5'd0,  5'd1,  5'd2,  32'h0000_0008, 32'h0020C463};
    tbl[19] = '{6'd17, 5'd1,  5'd1,  5'd0,  32'h0000_0001, 32'h0010D093};
    tbl[20] = '{6'd25, 5'd0,  5'd1,  5'd2,  32'h0000_0009, 32'h00208463};

    rst = 1'b1; load_start = 1'b0; start_addr = '0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; cmd_last = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_we",    {31'd0, imem_we}, 32'd0);
    chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_flags", {28'd0, busy, done, err_illegal, err_ovf}, 32'd0);
    chk("rst_count", {23'd0, word_count}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic single-command session
    start_session(8'h10);
    chk("s1_busy",  {31'd0, busy}, 32'd1);
    chk("s1_ready", {31'd0, cmd_ready}, 32'd1);
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    expect_write("s1", 8'h10, 32'h003100B3);
    tick();
    chk("s1_we_off", {31'd0, imem_we}, 32'd0);
    chk("s1_done",   {31'd0, done}, 32'd1);
    chk("s1_count",  {23'd0, word_count}, 32'd1);
    chk("s1_ready0", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("s1_done_pulse", {31'd0, done}, 32'd0);
    chk("s1_idle",       {31'd0, busy}, 32'd0);
    chk("s1_count_hold", {23'd0, word_count}, 32'd1);

    // Encoding table, one single-word session each
    for (int i = 0; i < 21; i++) begin
      start_session(8'h80 + 8'(i));
      send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b1);
      expect_write($sformatf("tbl%0d", i), 8'h80 + 8'(i), tbl[i].exp);
      tick();
      chk($sformatf("tbl%0d_done", i), {31'd0, done}, 32'd1);
      tick();
    end

    // Back-to-back commands land at consecutive addresses
    start_session(8'h10);
    send(6'd25, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    expect_write("seq0", 8'h10, 32'h00208463);
    tick();
    chk("seq_ready", {31'd0, cmd_ready}, 32'd1);
    send(6'd32, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1);
    expect_write("seq1", 8'h11, 32'h010000EF);
    tick();
    chk("seq_done",  {31'd0, done}, 32'd1);
    chk("seq_count", {23'd0, word_count}, 32'd2);
    tick();

    // Illegal op mid-session is skipped without consuming an address
    start_session(8'h30);
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    expect_write("ill0", 8'h30, 32'h003100B3);
    send(6'd40, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    chk("ill_no_we", {31'd0, imem_we}, 32'd0);
    chk("ill_err",   {31'd0, err_illegal}, 32'd1);
    chk("ill_ready", {31'd0, cmd_ready}, 32'd1);
    send(6'd2, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    expect_write("ill1", 8'h31, 32'h003140B3);
    tick();
    chk("ill_done",  {31'd0, done}, 32'd1);
    chk("ill_count", {23'd0, word_count}, 32'd2);
    tick();
    chk("ill_sticky", {31'd0, err_illegal}, 32'd1);
    start_session(8'h50);
    chk("ill_clear", {31'd0, err_illegal}, 32'd0);
    send(6'd33, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    chk("ill_last_no_we", {31'd0, imem_we}, 32'd0);
    chk("ill_last_err",   {31'd0, err_illegal}, 32'd1);
    chk("ill_last_done",  {31'd0, done}, 32'd1);
    chk("ill_last_count", {23'd0, word_count}, 32'd0);
    tick();
    chk("ill_last_idle", {31'd0, busy}, 32'd0);

    // Overflow with address wrap
    start_session(8'hFE);
    send(6'd12, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
    expect_write("ovf0", 8'hFE, 32'h00000093);
    send(6'd12, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0);
    expect_write("ovf1", 8'hFF, 32'h00100113);
    send(6'd12, 5'd3, 5'd0, 5'd0, 32'd2, 1'b0);
    expect_write("ovf2", 8'h00, 32'h00200193);
    chk("ovf_not_yet", {31'd0, err_ovf}, 32'd0);
    send(6'd12, 5'd4, 5'd0, 5'd0, 32'd3, 1'b0);
    expect_write("ovf3", 8'h01, 32'h00300213);
    tick();
    chk("ovf_done",  {31'd0, done}, 32'd1);
    chk("ovf_err",   {31'd0, err_ovf}, 32'd1);
    chk("ovf_count", {23'd0, word_count}, 32'd4);
    chk("ovf_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_op = 6'd0; cmd_last = 1'b0; cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ovf_blk_we%0d", k),    {31'd0, imem_we}, 32'd0);
      chk($sformatf("ovf_blk_ready%0d", k), {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    chk("ovf_sticky", {31'd0, err_ovf}, 32'd1);
    chk("ovf_hold",   {23'd0, word_count}, 32'd4);

    // Asynchronous reset while a write is on the bus
    start_session(8'h60);
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    chk("ar_we_before", {31'd0, imem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_we",    {31'd0, imem_we}, 32'd0);
    chk("ar_addr",  {24'd0, imem_addr}, 32'd0);
    chk("ar_wdata", imem_wdata, 32'd0);
    chk("ar_flags", {27'd0, cmd_ready, busy, done, err_illegal, err_ovf}, 32'd0);
    chk("ar_count", {23'd0, word_count}, 32'd0);
    #2 rst = 1'b0;
    tick();
    start_session(8'h70);
    send(6'd1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1);
    expect_write("ar_new", 8'h70, 32'h40628233);
    tick();
    chk("ar_new_done",  {31'd0, done}, 32'd1);
    chk("ar_new_count", {23'd0, word_count}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
